multicycle_control: RTL and testbench
=====================================

Name: multicycle_control

Overview:
- Main control FSM for the multi-cycle RV32I core.
- Decodes the IR opcode and drives every datapath enable and mux select per cycle.
- Produces the 3-bit ALUOp consumed by the ALU control decoder, which turns ALUOp plus funct3/funct7 into ALU control lines.
- Handshakes with the unified instruction/data memory port using request/ready.

Parameters:
- RESET_STATE, 4'd0 (FETCH): state entered on reset.

Ports:
- i_clk  input  1  core clock, rising edge.
- i_rst  input  1  synchronous, active-high reset.
- i_Opcode  input  7  IR[6:0].
- i_MemReady  input  1  memory completes current read/write this cycle.
- i_BranchTaken  input  1  comparator result for the current branch.
- o_ALUOp  output  3  000 I_L(add), 001 B(sub), 010 R, 011 I, 100 LUI, 101 AUIPC.
- o_ALUSrcA  output  2  00 PC, 01 rs1, 10 OldPC.
- o_ALUSrcB  output  2  00 rs2, 01 const 4, 10 imm.
- o_PCSource  output  2  00 ALU result, 01 ALUOut, 10 ALU result & ~1.
- o_MemToReg  output  2  00 ALUOut, 01 MDR, 10 PC (link).
- o_IorD  output  1  0 PC addresses memory, 1 ALUOut addresses memory.
- o_MemRead, o_MemWrite  output  1 each  memory requests.
- o_IRWrite  output  1  load IR and OldPC.
- o_PCWrite  output  1  unconditional PC load.
- o_PCWriteCond  output  1  PC load if i_BranchTaken.
- o_RegWrite  output  1  register file write enable.
- o_Illegal  output  1  unrecognised opcode flag.
- o_State  output  4  current state, for debug.

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high. While i_rst=1 at a rising edge: state <= FETCH and o_Illegal <= 0. During the reset cycle every enable output (MemRead, MemWrite, IRWrite, PCWrite, PCWriteCond, RegWrite) is forced to 0.
- Reset mid-transaction: the memory request drops the cycle after reset is sampled.
- Output decode: Moore decode from state. The only Mealy terms are IRWrite/PCWrite in FETCH and the state advance, which are gated by i_MemReady. Unlisted selects default to 0.
- State encoding: 0 FETCH, 1 DECODE, 2 MEM_ADDR, 3 MEM_READ, 4 MEM_WB, 5 MEM_WRITE, 6 EXEC_R, 7 EXEC_I, 8 ALU_WB, 9 BRANCH, 10 JAL, 11 JALR, 12 EXEC_LUI, 13 EXEC_AUIPC, 14 TRAP.
- FETCH: MemRead=1, IorD=0, SrcA=PC, SrcB=4, ALUOp=000, PCSource=00. When i_MemReady=1: IRWrite=1, PCWrite=1, go to DECODE. Otherwise hold with MemRead kept high.
- DECODE: SrcA=OldPC, SrcB=imm, ALUOp=000 (branch/JAL target to ALUOut). Dispatch on i_Opcode:
  - LOAD 0000011 and STORE 0100011 -> MEM_ADDR
  - OP 0110011 -> EXEC_R
  - OP_IMM 0010011 -> EXEC_I
  - BRANCH 1100011 -> BRANCH
  - JAL 1101111 -> JAL
  - JALR 1100111 -> JALR
  - LUI 0110111 -> EXEC_LUI
  - AUIPC 0010111 -> EXEC_AUIPC
  - anything else -> illegal handling (see Optional Feature).
- MEM_ADDR: SrcA=rs1, SrcB=imm, ALUOp=000. Go to MEM_READ if i_Opcode[5]=0, MEM_WRITE if i_Opcode[5]=1.
- MEM_READ: MemRead=1, IorD=1. Advance to MEM_WB on i_MemReady.
- MEM_WB: RegWrite=1, MemToReg=01 -> FETCH.
- MEM_WRITE: MemWrite=1, IorD=1. Advance to FETCH on i_MemReady.
- EXEC_R: SrcA=rs1, SrcB=rs2, ALUOp=010 -> ALU_WB.
- EXEC_I: SrcA=rs1, SrcB=imm, ALUOp=011 -> ALU_WB.
- EXEC_LUI: SrcB=imm, ALUOp=100 -> ALU_WB.
- EXEC_AUIPC: SrcA=OldPC, SrcB=imm, ALUOp=101 -> ALU_WB.
- ALU_WB: RegWrite=1, MemToReg=00 -> FETCH.
- BRANCH: SrcA=rs1, SrcB=rs2, ALUOp=001, PCWriteCond=1, PCSource=01 -> FETCH.
- JAL: PCWrite=1, PCSource=01, RegWrite=1, MemToReg=10 -> FETCH.
- JALR: SrcA=rs1, SrcB=imm, ALUOp=000, PCWrite=1, PCSource=10, RegWrite=1, MemToReg=10 -> FETCH.
- Link value: MemToReg=10 writes the PC register's current (already incremented) value, i.e. OldPC+4.
- Latencies with zero wait states: branch, JAL, JALR 3 cycles; R, I, LUI, AUIPC and store 4 cycles; load 5 cycles. Each memory wait cycle adds 1.
- Request ordering: MemRead and MemWrite are never high together.
- TRAP: all enables 0, o_Illegal=1. Exit only via reset.

Optional Feature:
- Macro: MULTICYCLE_CONTROL_ILLEGAL_TRAP_EN.
- Defined: an illegal opcode in DECODE moves to TRAP; o_Illegal is sticky, and the core halts until reset.
- Undefined: an illegal opcode in DECODE returns to FETCH, so the instruction executes as a NOP (PC already advanced). o_Illegal pulses high for that single DECODE cycle. The TRAP state is not generated.

Decomposition:
- Opcode constants stay in the shared opcode defines header.
- ALUOp encodings (I_L, B, R, I, LUI, AUIPC) move into the shared ALU control header so producer and decoder share one definition.
- State encodings plus the SrcA, SrcB, PCSource and MemToReg select constants go in a new control defines header.
- No sub-module; single FSM with a registered state and a combinational output decode.

Test Plan:
- add (0110011), i_MemReady always 1 -> states 0,1,6,8,0. ALUOp=010 in EXEC_R. RegWrite=1 only in ALU_WB.
- lw (0000011), i_MemReady low 2 cycles in MEM_READ -> MEM_READ held 3 cycles with MemRead=1, IorD=1. Then MEM_WB with MemToReg=01. Total 7 cycles.
- beq (1100011), i_BranchTaken=1 -> BRANCH asserts ALUOp=001, PCWriteCond=1, PCSource=01. Back in FETCH after 3 cycles.
- jalr (1100111) -> JALR asserts PCWrite=1, PCSource=10, RegWrite=1, MemToReg=10.
- Opcode 1111111 -> macro defined: TRAP, o_Illegal held 1 for 20 cycles. Macro undefined: one-cycle o_Illegal pulse, then FETCH.
- i_rst=1 during MEM_WRITE with i_MemReady=0 -> next cycle o_State=0, MemWrite=0, o_Illegal=0.

Source files
------------

// File: rtl/multicycle_control_pkg.sv
// Shared definitions for the multi-cycle RV32I control path.
//   - RV32I major opcodes (IR[6:0])
//   - ALUOp encodings shared by this FSM and the ALU control decoder
//   - control FSM state encodings
//   - datapath mux select constants (SrcA, SrcB, PCSource, MemToReg)
package multicycle_control_pkg;

    // Opcodes
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    // ALUOp consumed by the ALU control decoder
    typedef enum logic [2:0] {
        ALUOP_IL    = 3'b000,  // add: address / target calculation
        ALUOP_B     = 3'b001,  // sub: branch compare
        ALUOP_R     = 3'b010,
        ALUOP_I     = 3'b011,
        ALUOP_LUI   = 3'b100,
        ALUOP_AUIPC = 3'b101
    } alu_op_e;

    // Control FSM states
    typedef enum logic [3:0] {
        ST_FETCH      = 4'd0,
        ST_DECODE     = 4'd1,
        ST_MEM_ADDR   = 4'd2,
        ST_MEM_READ   = 4'd3,
        ST_MEM_WB     = 4'd4,
        ST_MEM_WRITE  = 4'd5,
        ST_EXEC_R     = 4'd6,
        ST_EXEC_I     = 4'd7,
        ST_ALU_WB     = 4'd8,
        ST_BRANCH     = 4'd9,
        ST_JAL        = 4'd10,
        ST_JALR       = 4'd11,
        ST_EXEC_LUI   = 4'd12,
        ST_EXEC_AUIPC = 4'd13,
        ST_TRAP       = 4'd14
    } state_e;

    // ALU source A
    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_RS1   = 2'b01;
    localparam logic [1:0] SRCA_OLDPC = 2'b10;

    // ALU source B
    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_FOUR = 2'b01;
    localparam logic [1:0] SRCB_IMM  = 2'b10;

    // PC source
    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JALR   = 2'b10;  // ALU result & ~1

    // Register file write-back source
    localparam logic [1:0] WB_ALUOUT = 2'b00;
    localparam logic [1:0] WB_MDR    = 2'b01;
    localparam logic [1:0] WB_LINK   = 2'b10;  // PC register, already OldPC+4

endpackage

// File: rtl/multicycle_control.sv
// Main control FSM of the multi-cycle RV32I core.
// Registered state, combinational Moore output decode. IRWrite/PCWrite in
// FETCH and every memory-state advance are gated by i_MemReady.
//
// Build option: MULTICYCLE_CONTROL_ILLEGAL_TRAP_EN
//   defined   : illegal opcode -> TRAP, o_Illegal sticky until reset
//   undefined : illegal opcode executes as NOP, o_Illegal pulses in DECODE
//
// Ports:
//   i_clk, i_rst        clock, synchronous active-high reset
//   i_Opcode            IR[6:0]
//   i_MemReady          memory completes the current access this cycle
//   i_BranchTaken       branch comparator result (gated in the datapath)
//   o_ALUOp             ALUOp to the ALU control decoder
//   o_ALUSrcA/B         ALU operand selects
//   o_PCSource          PC next-value select
//   o_MemToReg          register write-back select
//   o_IorD              memory address select
//   o_MemRead/Write     memory requests
//   o_IRWrite           load IR and OldPC
//   o_PCWrite           unconditional PC load
//   o_PCWriteCond       PC load qualified by i_BranchTaken
//   o_RegWrite          register file write enable
//   o_Illegal           unrecognised opcode flag
//   o_State             current state (debug)
//
// state         | meaning
// FETCH         | read instruction at PC, PC <= PC+4
// DECODE        | OldPC+imm -> ALUOut, dispatch on opcode
// MEM_ADDR      | rs1+imm -> ALUOut
// MEM_READ      | read data at ALUOut
// MEM_WB        | MDR -> rd
// MEM_WRITE     | write rs2 at ALUOut
// EXEC_R        | rs1 op rs2
// EXEC_I        | rs1 op imm
// ALU_WB        | ALUOut -> rd
// BRANCH        | compare, PC <= target if taken
// JAL           | PC <= target, rd <= link
// JALR          | PC <= (rs1+imm)&~1, rd <= link
// EXEC_LUI      | imm pass-through
// EXEC_AUIPC    | OldPC+imm
// TRAP          | halted on illegal opcode (trap build only)
module multicycle_control
    import multicycle_control_pkg::*;
#(
    parameter logic [3:0] RESET_STATE = 4'd0
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [6:0] i_Opcode,
    input  logic       i_MemReady,
    input  logic       i_BranchTaken,
    output logic [2:0] o_ALUOp,
    output logic [1:0] o_ALUSrcA,
    output logic [1:0] o_ALUSrcB,
    output logic [1:0] o_PCSource,
    output logic [1:0] o_MemToReg,
    output logic       o_IorD,
    output logic       o_MemRead,
    output logic       o_MemWrite,
    output logic       o_IRWrite,
    output logic       o_PCWrite,
    output logic       o_PCWriteCond,
    output logic       o_RegWrite,
    output logic       o_Illegal,
    output logic [3:0] o_State
);

    state_e state;
    state_e next_state;

    // The branch decision is applied in the datapath via PCWriteCond.
    logic unused_branch_taken;
    assign unused_branch_taken = i_BranchTaken;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= state_e'(RESET_STATE);
        end else begin
            state <= next_state;
        end
    end

    assign o_State = state;

    always_comb begin
        next_state    = state;
        o_ALUOp       = ALUOP_IL;
        o_ALUSrcA     = SRCA_PC;
        o_ALUSrcB     = SRCB_RS2;
        o_PCSource    = PCSRC_ALU;
        o_MemToReg    = WB_ALUOUT;
        o_IorD        = 1'b0;
        o_MemRead     = 1'b0;
        o_MemWrite    = 1'b0;
        o_IRWrite     = 1'b0;
        o_PCWrite     = 1'b0;
        o_PCWriteCond = 1'b0;
        o_RegWrite    = 1'b0;
        o_Illegal     = 1'b0;

        case (state)
            ST_FETCH: begin
                o_MemRead = 1'b1;
                o_ALUSrcB = SRCB_FOUR;
                if (i_MemReady) begin
                    o_IRWrite  = 1'b1;
                    o_PCWrite  = 1'b1;
                    next_state = ST_DECODE;
                end
            end
            ST_DECODE: begin
                o_ALUSrcA = SRCA_OLDPC;
                o_ALUSrcB = SRCB_IMM;
                case (i_Opcode)
                    OPC_LOAD, OPC_STORE: next_state = ST_MEM_ADDR;
                    OPC_OP:              next_state = ST_EXEC_R;
                    OPC_OP_IMM:          next_state = ST_EXEC_I;
                    OPC_BRANCH:          next_state = ST_BRANCH;
                    OPC_JAL:             next_state = ST_JAL;
                    OPC_JALR:            next_state = ST_JALR;
                    OPC_LUI:             next_state = ST_EXEC_LUI;
                    OPC_AUIPC:           next_state = ST_EXEC_AUIPC;
                    default: begin
                        o_Illegal = 1'b1;
`ifdef MULTICYCLE_CONTROL_ILLEGAL_TRAP_EN
                        next_state = ST_TRAP;
`else
                        // PC already advanced in FETCH: behaves as a NOP.
                        next_state = ST_FETCH;
`endif
                    end
                endcase
            end
            ST_MEM_ADDR: begin
                o_ALUSrcA  = SRCA_RS1;
                o_ALUSrcB  = SRCB_IMM;
                // opcode bit 5 separates STORE from LOAD
                next_state = i_Opcode[5] ? ST_MEM_WRITE : ST_MEM_READ;
            end
            ST_MEM_READ: begin
                o_MemRead = 1'b1;
                o_IorD    = 1'b1;
                if (i_MemReady) next_state = ST_MEM_WB;
            end
            ST_MEM_WB: begin
                o_RegWrite = 1'b1;
                o_MemToReg = WB_MDR;
                next_state = ST_FETCH;
            end
            ST_MEM_WRITE: begin
                o_MemWrite = 1'b1;
                o_IorD     = 1'b1;
                if (i_MemReady) next_state = ST_FETCH;
            end
            ST_EXEC_R: begin
                o_ALUSrcA  = SRCA_RS1;
                o_ALUSrcB  = SRCB_RS2;
                o_ALUOp    = ALUOP_R;
                next_state = ST_ALU_WB;
            end
            ST_EXEC_I: begin
                o_ALUSrcA  = SRCA_RS1;
                o_ALUSrcB  = SRCB_IMM;
                o_ALUOp    = ALUOP_I;
                next_state = ST_ALU_WB;
            end
            ST_EXEC_LUI: begin
                o_ALUSrcB  = SRCB_IMM;
                o_ALUOp    = ALUOP_LUI;
                next_state = ST_ALU_WB;
            end
            ST_EXEC_AUIPC: begin
                o_ALUSrcA  = SRCA_OLDPC;
                o_ALUSrcB  = SRCB_IMM;
                o_ALUOp    = ALUOP_AUIPC;
                next_state = ST_ALU_WB;
            end
            ST_ALU_WB: begin
                o_RegWrite = 1'b1;
                o_MemToReg = WB_ALUOUT;
                next_state = ST_FETCH;
            end
            ST_BRANCH: begin
                o_ALUSrcA     = SRCA_RS1;
                o_ALUSrcB     = SRCB_RS2;
                o_ALUOp       = ALUOP_B;
                o_PCWriteCond = 1'b1;
                o_PCSource    = PCSRC_ALUOUT;
                next_state    = ST_FETCH;
            end
            ST_JAL: begin
                o_PCWrite  = 1'b1;
                o_PCSource = PCSRC_ALUOUT;
                o_RegWrite = 1'b1;
                o_MemToReg = WB_LINK;
                next_state = ST_FETCH;
            end
            ST_JALR: begin
                o_ALUSrcA  = SRCA_RS1;
                o_ALUSrcB  = SRCB_IMM;
                o_PCWrite  = 1'b1;
                o_PCSource = PCSRC_JALR;
                o_RegWrite = 1'b1;
                o_MemToReg = WB_LINK;
                next_state = ST_FETCH;
            end
`ifdef MULTICYCLE_CONTROL_ILLEGAL_TRAP_EN
            ST_TRAP: begin
                o_Illegal  = 1'b1;
                next_state = ST_TRAP;
            end
`endif
            default: next_state = ST_FETCH;
        endcase

        // Enables are suppressed while reset is being sampled so an
        // in-flight memory request never outlives the reset cycle.
        if (i_rst) begin
            o_MemRead     = 1'b0;
            o_MemWrite    = 1'b0;
            o_IRWrite     = 1'b0;
            o_PCWrite     = 1'b0;
            o_PCWriteCond = 1'b0;
            o_RegWrite    = 1'b0;
            o_Illegal     = 1'b0;
        end
    end

endmodule

// File: tb/tb_multicycle_control.sv
module tb_multicycle_control;

    logic       i_clk = 1'b0;
    logic       i_rst;
    logic [6:0] i_Opcode;
    logic       i_MemReady;
    logic       i_BranchTaken;
    logic [2:0] o_ALUOp;
    logic [1:0] o_ALUSrcA, o_ALUSrcB, o_PCSource, o_MemToReg;
    logic       o_IorD, o_MemRead, o_MemWrite, o_IRWrite, o_PCWrite;
    logic       o_PCWriteCond, o_RegWrite, o_Illegal;
    logic [3:0] o_State;

    multicycle_control dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_Opcode(i_Opcode),
        .i_MemReady(i_MemReady), .i_BranchTaken(i_BranchTaken),
        .o_ALUOp(o_ALUOp), .o_ALUSrcA(o_ALUSrcA), .o_ALUSrcB(o_ALUSrcB),
        .o_PCSource(o_PCSource), .o_MemToReg(o_MemToReg), .o_IorD(o_IorD),
        .o_MemRead(o_MemRead), .o_MemWrite(o_MemWrite), .o_IRWrite(o_IRWrite),
        .o_PCWrite(o_PCWrite), .o_PCWriteCond(o_PCWriteCond),
        .o_RegWrite(o_RegWrite), .o_Illegal(o_Illegal), .o_State(o_State)
    );

    always #5 i_clk = ~i_clk;

    // Expected vector layout:
    // {state[3:0], aluop[2:0], srca[1:0], srcb[1:0], pcsrc[1:0], m2r[1:0],
    //  iord, memread, memwrite, irwrite, pcwrite, pcwritecond, regwrite, illegal}
    typedef struct {
        string       tag;
        logic [22:0] vec;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    function automatic logic [22:0] ev(input logic [3:0] st, input logic [2:0] alu,
                                       input logic [1:0] a, input logic [1:0] b,
                                       input logic [1:0] pcs, input logic [1:0] m2r,
                                       input logic [7:0] fl);
        return {st, alu, a, b, pcs, m2r, fl};
    endfunction

    // Common per-state vectors (hand-derived from the state descriptions)
    logic [22:0] E_FETCH_RDY, E_FETCH_WAIT, E_DECODE, E_ALU_WB;
    initial begin
        E_FETCH_RDY  = ev(4'd0, 3'd0, 2'd0, 2'd1, 2'd0, 2'd0, 8'b0101_1000);
        E_FETCH_WAIT = ev(4'd0, 3'd0, 2'd0, 2'd1, 2'd0, 2'd0, 8'b0100_0000);
        E_DECODE     = ev(4'd1, 3'd0, 2'd2, 2'd2, 2'd0, 2'd0, 8'b0000_0000);
        E_ALU_WB     = ev(4'd8, 3'd0, 2'd0, 2'd0, 2'd0, 2'd0, 8'b0000_0010);
    end

    // Drive one cycle of inputs and queue the output expected in that cycle.
    task automatic step(input string tag, input logic [6:0] opc, input logic rdy,
                        input logic bt, input logic rst, input logic [22:0] e);
        exp_t x;
        i_Opcode      = opc;
        i_MemReady    = rdy;
        i_BranchTaken = bt;
        i_rst         = rst;
        x.tag = tag;
        x.vec = e;
        exp_q.push_back(x);
        @(posedge i_clk);
        #1;
    endtask

    // Monitor: every cycle the DUT presents a full control word; compare it
    // mid-cycle against the oldest queued expectation.
    always @(negedge i_clk) begin
        logic [22:0] act;
        exp_t        x;
        act = {o_State, o_ALUOp, o_ALUSrcA, o_ALUSrcB, o_PCSource, o_MemToReg,
               o_IorD, o_MemRead, o_MemWrite, o_IRWrite, o_PCWrite,
               o_PCWriteCond, o_RegWrite, o_Illegal};
        if (exp_q.size() > 0) begin
            x = exp_q.pop_front();
            n_checks++;
            if (act !== x.vec) begin
                n_errors++;
                $display("FAIL %s: got %06h expected %06h (state %0d)",
                         x.tag, act, x.vec, o_State);
            end
            n_checks++;
            if (o_MemRead && o_MemWrite) begin
                n_errors++;
                $display("FAIL %s_req_order: got rd=%b wr=%b expected not both",
                         x.tag, o_MemRead, o_MemWrite);
            end
        end
    end

    initial begin
        i_rst = 1'b1; i_Opcode = 7'd0; i_MemReady = 1'b0; i_BranchTaken = 1'b0;
        @(posedge i_clk); @(posedge i_clk); #1;

        // reset cycle: FETCH selects, enables forced low
        step("reset", 7'b0110011, 1'b1, 1'b0, 1'b1,
             ev(4'd0, 3'd0, 2'd0, 2'd1, 2'd0, 2'd0, 8'b0000_0000));

        // add: 0,1,6,8
        step("add_fetch",  7'b0110011, 1'b1, 1'b0, 1'b0, E_FETCH_RDY);
        step("add_decode", 7'b0110011, 1'b1, 1'b0, 1'b0, E_DECODE);
        step("add_exec",   7'b0110011, 1'b1, 1'b0, 1'b0,
             ev(4'd6, 3'd2, 2'd1, 2'd0, 2'd0, 2'd0, 8'b0000_0000));
        step("add_wb",     7'b0110011, 1'b1, 1'b0, 1'b0, E_ALU_WB);

        // lw with one fetch wait and two MEM_READ waits
        step("lw_fetch_wait", 7'b0000011, 1'b0, 1'b0, 1'b0, E_FETCH_WAIT);
        step("lw_fetch",      7'b0000011, 1'b1, 1'b0, 1'b0, E_FETCH_RDY);
        step("lw_decode",     7'b0000011, 1'b1, 1'b0, 1'b0, E_DECODE);
        step("lw_addr",       7'b0000011, 1'b1, 1'b0, 1'b0,
             ev(4'd2, 3'd0, 2'd1, 2'd2, 2'd0, 2'd0, 8'b0000_0000));
        step("lw_read_w0",    7'b0000011, 1'b0, 1'b0, 1'b0,
             ev(4'd3, 3'd0, 2'd0, 2'd0, 2'd0, 2'd0, 8'b1100_0000));
        step("lw_read_w1",    7'b0000011, 1'b0, 1'b0, 1'b0,
             ev(4'd3, 3'd0, 2'd0, 2'd0, 2'd0, 2'd0, 8'b1100_0000));
        step("lw_read",       7'b0000011, 1'b1, 1'b0, 1'b0,
             ev(4'd3, 3'd0, 2'd0, 2'd0, 2'd0, 2'd0, 8'b1100_0000));
        step("lw_wb",         7'b0000011, 1'b1, 1'b0, 1'b0,
             ev(4'd4, 3'd0, 2'd0, 2'd0, 2'd0, 2'd1, 8'b0000_0010));

        // beq taken: 3 cycles
        step("beq_fetch",  7'b1100011, 1'b1, 1'b1, 1'b0, E_FETCH_RDY);
        step("beq_decode", 7'b1100011, 1'b1, 1'b1, 1'b0, E_DECODE);
        step("beq_branch", 7'b1100011, 1'b1, 1'b1, 1'b0,
             ev(4'd9, 3'd1, 2'd1, 2'd0, 2'd1, 2'd0, 8'b0000_0100));

        // jalr
        step("jalr_fetch",  7'b1100111, 1'b1, 1'b0, 1'b0, E_FETCH_RDY);
        step("jalr_decode", 7'b1100111, 1'b1, 1'b0, 1'b0, E_DECODE);
        step("jalr_exec",   7'b1100111, 1'b1, 1'b0, 1'b0,
             ev(4'd11, 3'd0, 2'd1, 2'd2, 2'd2, 2'd2, 8'b0000_1010));

        // jal
        step("jal_fetch",  7'b1101111, 1'b1, 1'b0, 1'b0, E_FETCH_RDY);
        step("jal_decode", 7'b1101111, 1'b1, 1'b0, 1'b0, E_DECODE);
        step("jal_exec",   7'b1101111, 1'b1, 1'b0, 1'b0,
             ev(4'd10, 3'd0, 2'd0, 2'd0, 2'd1, 2'd2, 8'b0000_1010));

        // sw, zero wait: 4 cycles
        step("sw_fetch",  7'b0100011, 1'b1, 1'b0, 1'b0, E_FETCH_RDY);
        step("sw_decode", 7'b0100011, 1'b1, 1'b0, 1'b0, E_DECODE);
        step("sw_addr",   7'b0100011, 1'b1, 1'b0, 1'b0,
             ev(4'd2, 3'd0, 2'd1, 2'd2, 2'd0, 2'd0, 8'b0000_0000));
        step("sw_write",  7'b0100011, 1'b1, 1'b0, 1'b0,
             ev(4'd5, 3'd0, 2'd0, 2'd0, 2'd0, 2'd0, 8'b1010_0000));

        // addi, lui, auipc
        step("addi_fetch",  7'b0010011, 1'b1, 1'b0, 1'b0, E_FETCH_RDY);
        step("addi_decode", 7'b0010011, 1'b1, 1'b0, 1'b0, E_DECODE);
        step("addi_exec",   7'b0010011, 1'b1, 1'b0, 1'b0,
             ev(4'd7, 3'd3, 2'd1, 2'd2, 2'd0, 2'd0, 8'b0000_0000));
        step("addi_wb",     7'b0010011, 1'b1, 1'b0, 1'b0, E_ALU_WB);
        step("lui_fetch",   7'b0110111, 1'b1, 1'b0, 1'b0, E_FETCH_RDY);
        step("lui_decode",  7'b0110111, 1'b1, 1'b0, 1'b0, E_DECODE);
        step("lui_exec",    7'b0110111, 1'b1, 1'b0, 1'b0,
             ev(4'd12, 3'd4, 2'd0, 2'd2, 2'd0, 2'd0, 8'b0000_0000));
        step("lui_wb",      7'b0110111, 1'b1, 1'b0, 1'b0, E_ALU_WB);
        step("auipc_fetch", 7'b0010111, 1'b1, 1'b0, 1'b0, E_FETCH_RDY);
        step("auipc_decode",7'b0010111, 1'b1, 1'b0, 1'b0, E_DECODE);
        step("auipc_exec",  7'b0010111, 1'b1, 1'b0, 1'b0,
             ev(4'd13, 3'd5, 2'd2, 2'd2, 2'd0, 2'd0, 8'b0000_0000));
        step("auipc_wb",    7'b0010111, 1'b1, 1'b0, 1'b0, E_ALU_WB);

        // reset while MEM_WRITE is waiting
        step("rst_fetch",  7'b0100011, 1'b1, 1'b0, 1'b0, E_FETCH_RDY);
        step("rst_decode", 7'b0100011, 1'b1, 1'b0, 1'b0, E_DECODE);
        step("rst_addr",   7'b0100011, 1'b1, 1'b0, 1'b0,
             ev(4'd2, 3'd0, 2'd1, 2'd2, 2'd0, 2'd0, 8'b0000_0000));
        step("rst_write_wait", 7'b0100011, 1'b0, 1'b0, 1'b0,
             ev(4'd5, 3'd0, 2'd0, 2'd0, 2'd0, 2'd0, 8'b1010_0000));
        step("rst_write_rst",  7'b0100011, 1'b0, 1'b0, 1'b1,
             ev(4'd5, 3'd0, 2'd0, 2'd0, 2'd0, 2'd0, 8'b1000_0000));
        step("rst_after", 7'b0100011, 1'b0, 1'b0, 1'b0, E_FETCH_WAIT);

        // illegal opcode 1111111
        step("ill_fetch",  7'b1111111, 1'b1, 1'b0, 1'b0, E_FETCH_RDY);
        step("ill_decode", 7'b1111111, 1'b1, 1'b0, 1'b0,
             ev(4'd1, 3'd0, 2'd2, 2'd2, 2'd0, 2'd0, 8'b0000_0001));
`ifdef MULTICYCLE_CONTROL_ILLEGAL_TRAP_EN
        for (int i = 0; i < 20; i++)
            step("ill_trap", 7'b0110011, 1'b1, 1'b0, 1'b0,
                 ev(4'd14, 3'd0, 2'd0, 2'd0, 2'd0, 2'd0, 8'b0000_0000 | 8'd1));
        step("ill_trap_rst", 7'b0110011, 1'b1, 1'b0, 1'b1,
             ev(4'd14, 3'd0, 2'd0, 2'd0, 2'd0, 2'd0, 8'b0000_0000));
        step("ill_recover", 7'b0110011, 1'b1, 1'b0, 1'b0, E_FETCH_RDY);
`else
        step("ill_nop_fetch", 7'b0110011, 1'b1, 1'b0, 1'b0, E_FETCH_RDY);
        step("ill_nop_decode", 7'b0110011, 1'b1, 1'b0, 1'b0, E_DECODE);
`endif

        // bounded drain of the scoreboard
        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge i_clk);
        #2;
        n_checks++;
        if (exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
